pipeline_scoreboard: RTL and testbench
======================================

// Module: pipeline_scoreboard
// PURPOSE
//  Register-hazard scoreboard sequencing pipeline_decode -> execute issue.
//  - Tracks in-flight writes per architectural register (issued, not yet written back).
//  - Gates decode's issue handshake when a source or destination register is pending.
//  - Sits beside the decode stage: fed by decode's r1/r2/dst fields, cleared by writeback.
// PARAMETERS
//  NUM_REGS     32  architectural integer registers (x0 hardwired zero)
//  REG_IDX_W    5   register index width
//  MAX_PENDING  3   max outstanding writes per register; CNT_W = $clog2(MAX_PENDING+1)
//  TOTAL_W      6   width of total in-flight counter
// PORTS
//  clk            in   1          clock, all state on rising edge
//  reset          in   1          asynchronous, active-low reset
//  dec_valid      in   1          decode presents a non-NOP instruction
//  dec_r1_reg     in   REG_IDX_W  source 1 index
//  dec_r1_used    in   1          source 1 is read (0 for IMM-only / JAL)
//  dec_r2_reg     in   REG_IDX_W  source 2 index
//  dec_r2_used    in   1          source 2 is read (imm_or_reg2 == REG2)
//  dec_dst_reg    in   REG_IDX_W  destination index
//  dec_dst_used   in   1          instruction writes dst
//  ex_ready       in   1          execute stage can accept
//  issue_ready    out  1          scoreboard permits issue (comb)
//  issue_fire     out  1          dec_valid & issue_ready & ex_ready (comb)
//  wb_valid       in   1          writeback retires one register write
//  wb_dst_reg     in   REG_IDX_W  retired destination index
//  flush          in   1          sync squash of all in-flight ops (branch/jump redirect)
//  busy_mask      out  NUM_REGS   bit i = 1 iff cnt[i] != 0 (registered)
//  inflight_total out  TOTAL_W    sum of all cnt[i] (registered)
//  err_underflow  out  1          sticky: wb to register with cnt == 0
// BEHAVIOUR
//  - Reset (reset==0, async): all cnt[i]=0, busy_mask=0, inflight_total=0,
//    err_underflow=0, state=RUN. issue_ready=0 while reset asserted.
//  - Index 0 never tracked: issue/wb to x0 do not touch counters; sources x0 never hazard.
//  - Source hazard src: used & idx!=0 & cnt[idx]!=0, except cnt[idx]==1 with
//    wb_valid & wb_dst_reg==idx in the same cycle (same-cycle WB bypass) -> no hazard.
//  - Dest hazard: dec_dst_used & dst!=0 & cnt[dst]==MAX_PENDING and no same-cycle wb to dst.
//  - issue_ready = state==RUN & !flush & !src1_haz & !src2_haz & !dst_haz.
//  - On issue_fire with dst tracked: cnt[dst] += 1 next edge. On wb_valid: cnt[wb] -= 1.
//  - Same register, same cycle issue+wb: cnt unchanged. Different registers: both apply.
//  - wb to cnt==0: cnt stays 0 (no wrap), err_underflow set until reset.
//  - inflight_total tracks +issue_fire(dst tracked) -wb(valid decrement), same edge as cnt.
//  - Latency: counters/busy_mask/inflight_total update 1 cycle after event; issue_ready
//    is combinational on current state and inputs (0-cycle stall decision).
//  - FSM: RUN -> DRAIN when flush=1. DRAIN: all cnt, busy_mask, inflight_total cleared
//    on entry edge; issue_ready=0; wb_valid ignored (squashed results). DRAIN -> RUN
//    after one cycle with flush=0; flush held high keeps DRAIN.
//  - flush wins over a simultaneous issue_fire (issue_fire forced 0 when flush=1).
//  - Reset mid-operation: immediate clear regardless of state; no pending-write memory.
// TESTING
//  1 Reset: hold reset=0 3 cycles -> busy_mask=0, inflight_total=0, issue_ready=0;
//    release -> issue_ready=1 with dec_valid=1, no sources used.
//  2 RAW stall: issue ADDI x5 (dst=5); next cycle ADD r1=5 -> issue_ready=0 until
//    wb_valid wb_dst_reg=5; bypass cycle -> issue_ready=1 in that same cycle.
//  3 x0: issue dst=0, then r1=0 -> busy_mask stays 0, no stall, inflight_total=0.
//  4 Saturation: 3 issues to dst=7 -> cnt[7]=3, 4th stalls; wb 7 + issue 7 same cycle
//    -> issue allowed, cnt[7] stays 3, inflight_total stays 3.
//  5 Flush: 4 regs pending, flush=1 with dec_valid -> issue_fire=0, next cycle
//    busy_mask=0, inflight_total=0; wb during DRAIN ignored; RUN one cycle after flush=0.
//  6 Underflow: wb_valid dst=9 with cnt[9]=0 -> err_underflow=1, cnt[9]=0, sticky to reset.

Source files
------------

// File: rtl/pipeline_scoreboard_if.sv
// ---------------------------------------------------------------------------
// pipeline_scoreboard_if
// Purpose : Bundles the decode-side issue handshake, the writeback retire
//           port, the flush request and the scoreboard status outputs.
// Modports:
//   master : the pipeline side. It drives the decode fields, ex_ready,
//            writeback and flush, and observes the issue decision and status.
//   slave  : the scoreboard itself. It consumes those inputs and drives
//            issue_ready, issue_fire, busy_mask, inflight_total and
//            err_underflow.
// Signals :
//   dec_valid, dec_r1_reg/used, dec_r2_reg/used, dec_dst_reg/used, ex_ready
//   issue_ready, issue_fire
//   wb_valid, wb_dst_reg, flush
//   busy_mask, inflight_total, err_underflow
// ---------------------------------------------------------------------------
interface pipeline_scoreboard_if #(
   parameter int NUM_REGS  = 32,
   parameter int REG_IDX_W = 5,
   parameter int TOTAL_W   = 6
);
   logic                 dec_valid;
   logic [REG_IDX_W-1:0] dec_r1_reg;
   logic                 dec_r1_used;
   logic [REG_IDX_W-1:0] dec_r2_reg;
   logic                 dec_r2_used;
   logic [REG_IDX_W-1:0] dec_dst_reg;
   logic                 dec_dst_used;
   logic                 ex_ready;
   logic                 issue_ready;
   logic                 issue_fire;
   logic                 wb_valid;
   logic [REG_IDX_W-1:0] wb_dst_reg;
   logic                 flush;
   logic [NUM_REGS-1:0]  busy_mask;
   logic [TOTAL_W-1:0]   inflight_total;
   logic                 err_underflow;

   // The pipeline drives requests and watches the scoreboard's verdict
   modport master (
      output dec_valid, dec_r1_reg, dec_r1_used, dec_r2_reg, dec_r2_used,
             dec_dst_reg, dec_dst_used, ex_ready, wb_valid, wb_dst_reg, flush,
      input  issue_ready, issue_fire, busy_mask, inflight_total, err_underflow
   );

   // The scoreboard consumes requests and produces the verdict and status
   modport slave (
      input  dec_valid, dec_r1_reg, dec_r1_used, dec_r2_reg, dec_r2_used,
             dec_dst_reg, dec_dst_used, ex_ready, wb_valid, wb_dst_reg, flush,
      output issue_ready, issue_fire, busy_mask, inflight_total, err_underflow
   );
endinterface

// File: rtl/pipeline_scoreboard.sv
// ---------------------------------------------------------------------------
// pipeline_scoreboard
// Purpose : Register-hazard scoreboard between decode and execute. It keeps a
//           small counter of outstanding writes for every architectural
//           register. It blocks issue when a source register has a pending
//           write or when a destination counter is full. Counters are
//           released by writeback and wiped by a flush.
// Ports   :
//   clk    in  clock, all state changes on the rising edge
//   reset  in  asynchronous, active-low reset
//   sb     slave modport of pipeline_scoreboard_if, which carries the
//          decode fields, ex_ready, writeback, flush, issue_ready,
//          issue_fire, busy_mask, inflight_total and err_underflow
// ---------------------------------------------------------------------------
module pipeline_scoreboard #(
   parameter int NUM_REGS    = 32,
   parameter int REG_IDX_W   = 5,
   parameter int MAX_PENDING = 3,
   parameter int TOTAL_W     = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   pipeline_scoreboard_if.slave  sb
);

   localparam int               CNT_W   = $clog2(MAX_PENDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {
      RUN,
      DRAIN
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q [NUM_REGS];
   logic [CNT_W-1:0]     cnt_d [NUM_REGS];
   logic [NUM_REGS-1:0]  busy_q, busy_d;
   logic [TOTAL_W-1:0]   total_q, total_d;
   logic                 err_q, err_d;

   logic [CNT_W-1:0]     r1Cnt, r2Cnt, dstCnt, wbCnt;
   logic                 src1Haz, src2Haz, dstHaz;
   logic                 issueReady, issueFire;
   logic                 incEn, wbAccept, decValid, sameReg, underflowHit;

   // Look up the counters for every register that decode or writeback names
   // this cycle.
   assign r1Cnt  = cnt_q[sb.dec_r1_reg];
   assign r2Cnt  = cnt_q[sb.dec_r2_reg];
   assign dstCnt = cnt_q[sb.dec_dst_reg];
   assign wbCnt  = cnt_q[sb.wb_dst_reg];

   // Hazard detection. A source is only blocked by a pending write to it.
   // If the last pending write retires in this same cycle, its result is
   // bypassed, so the source is not a hazard. A destination is blocked only
   // when its counter is full and no writeback frees a slot this cycle.
   // Register x0 never creates a hazard.
   always_comb begin
      src1Haz = 1'b0;
      src2Haz = 1'b0;
      dstHaz  = 1'b0;
      if (sb.dec_r1_used && (sb.dec_r1_reg != '0) && (r1Cnt != '0)) begin
         src1Haz = !((r1Cnt == CNT_ONE) && sb.wb_valid &&
                     (sb.wb_dst_reg == sb.dec_r1_reg));
      end
      if (sb.dec_r2_used && (sb.dec_r2_reg != '0) && (r2Cnt != '0)) begin
         src2Haz = !((r2Cnt == CNT_ONE) && sb.wb_valid &&
                     (sb.wb_dst_reg == sb.dec_r2_reg));
      end
      if (sb.dec_dst_used && (sb.dec_dst_reg != '0) && (dstCnt == CNT_MAX)) begin
         dstHaz = !(sb.wb_valid && (sb.wb_dst_reg == sb.dec_dst_reg));
      end
   end

   // The issue decision is combinational. It is held low while reset is
   // asserted, while draining, and during a flush cycle, so a flush
   // always beats a simultaneous issue.
   assign issueReady = reset && (state_q == RUN) && !sb.flush &&
                       !src1Haz && !src2Haz && !dstHaz;
   assign issueFire  = sb.dec_valid && issueReady && sb.ex_ready;

   assign sb.issue_ready    = issueReady;
   assign sb.issue_fire     = issueFire;
   assign sb.busy_mask      = busy_q;
   assign sb.inflight_total = total_q;
   assign sb.err_underflow  = err_q;

   // Qualify the counter events. A writeback only counts in RUN outside a
   // flush, because results are squashed otherwise. Writes to x0 are never
   // tracked. An issue and a writeback to the same register cancel out.
   always_comb begin
      incEn        = issueFire && sb.dec_dst_used && (sb.dec_dst_reg != '0);
      wbAccept     = sb.wb_valid && (state_q == RUN) && !sb.flush &&
                     (sb.wb_dst_reg != '0);
      decValid     = wbAccept && (wbCnt != '0);
      underflowHit = wbAccept && (wbCnt == '0);
      sameReg      = incEn && wbAccept && (sb.dec_dst_reg == sb.wb_dst_reg);
   end

   // Next-state for the counters, the busy mask, the running total and the
   // sticky error flag. A flush clears every counter on the edge that
   // enters DRAIN. The dst hazard guarantees an increment never overflows
   // a counter. inflight_total wraps if more than 2**TOTAL_W-1 writes are
   // outstanding.
   always_comb begin
      total_d = total_q;
      err_d   = err_q | underflowHit;
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (sb.flush) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = '0;
         end
         total_d = '0;
      end else if (!sameReg) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (incEn && (sb.dec_dst_reg == REG_IDX_W'(i))) begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (decValid && (sb.wb_dst_reg == REG_IDX_W'(i))) begin
               cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
         end
         total_d = total_q + TOTAL_W'(incEn) - TOTAL_W'(decValid);
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         busy_d[i] = (cnt_d[i] != '0);
      end
   end

   // FSM next state. A flush enters DRAIN, and DRAIN stays put while flush
   // remains high. The first cycle in DRAIN with flush low returns to RUN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (sb.flush) state_d = DRAIN;
         DRAIN:   if (!sb.flush) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // State register. Reset clears everything immediately, so no record of
   // a pending write survives a reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         busy_q  <= '0;
         total_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         total_q <= total_d;
         err_q   <= err_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_pipeline_scoreboard
// Purpose : Self-checking bench for pipeline_scoreboard. A reference model
//           keeps the pending-write count of each register as plain integers
//           and derives the expected issue decision and status from them.
//           Directed scenarios run first, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_pipeline_scoreboard;

   localparam int NR   = 32;
   localparam int IW   = 5;
   localparam int MAXP = 3;
   localparam int TW   = 6;

   logic clk = 1'b0;
   logic reset;

   int checkCount = 0;
   int errorCount = 0;

   // Reference model state
   int pend [NR];
   bit drainM;
   bit errM;

   bit obsReady, obsFire;

   pipeline_scoreboard_if #(.NUM_REGS(NR), .REG_IDX_W(IW), .TOTAL_W(TW)) sbIf ();

   pipeline_scoreboard #(
      .NUM_REGS(NR), .REG_IDX_W(IW), .MAX_PENDING(MAXP), .TOTAL_W(TW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sbIf)
   );

   // Free-running clock with a 10 ns period
   always #5 clk = ~clk;

   // Single comparison point. It counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Clear the model to its reset state
   task automatic clearModel();
      for (int i = 0; i < NR; i++) pend[i] = 0;
      drainM = 1'b0;
      errM   = 1'b0;
   endtask

   // A source is blocked by an outstanding write unless the last one retires now
   function automatic bit srcBlocked(bit used, int idx, bit wbv, int wbd);
      if (!used || idx == 0 || pend[idx] == 0) return 1'b0;
      return !(pend[idx] == 1 && wbv && wbd == idx);
   endfunction

   // Compare the registered status outputs with the model's counts
   task automatic checkRegs(input string tag);
      logic [63:0] expBusy;
      int          sum;
      expBusy = '0;
      sum     = 0;
      for (int i = 0; i < NR; i++) begin
         if (pend[i] != 0) expBusy[i] = 1'b1;
         sum += pend[i];
      end
      checkOutput({tag, ".busy"},  64'(sbIf.busy_mask), expBusy);
      checkOutput({tag, ".total"}, 64'(sbIf.inflight_total), 64'(sum % (1 << TW)));
      checkOutput({tag, ".err"},   64'(sbIf.err_underflow), 64'(errM));
   endtask

   // Run one clock cycle. Call this just after a falling edge. It drives the
   // inputs, checks the combinational decision, advances the model, and then
   // checks the registered outputs after the rising edge.
   task automatic applyStimulus(input bit dv, input int r1, input bit r1u,
                                input int r2, input bit r2u, input int dst,
                                input bit du, input bit exr, input bit wbv,
                                input int wbd, input bit fl);
      bit expReady, expFire, issueT, wbT;
      sbIf.dec_valid    = dv;
      sbIf.dec_r1_reg   = IW'(r1);
      sbIf.dec_r1_used  = r1u;
      sbIf.dec_r2_reg   = IW'(r2);
      sbIf.dec_r2_used  = r2u;
      sbIf.dec_dst_reg  = IW'(dst);
      sbIf.dec_dst_used = du;
      sbIf.ex_ready     = exr;
      sbIf.wb_valid     = wbv;
      sbIf.wb_dst_reg   = IW'(wbd);
      sbIf.flush        = fl;
      #1;
      expReady = reset && !drainM && !fl &&
                 !srcBlocked(r1u, r1, wbv, wbd) && !srcBlocked(r2u, r2, wbv, wbd) &&
                 !(du && dst != 0 && pend[dst] == MAXP && !(wbv && wbd == dst));
      expFire  = dv && expReady && exr;
      obsReady = sbIf.issue_ready;
      obsFire  = sbIf.issue_fire;
      checkOutput("issue_ready", 64'(obsReady), 64'(expReady));
      checkOutput("issue_fire",  64'(obsFire),  64'(expFire));
      if (!reset) begin
         clearModel();
      end else if (fl) begin
         for (int i = 0; i < NR; i++) pend[i] = 0;
         drainM = 1'b1;
      end else if (drainM) begin
         drainM = 1'b0;
      end else begin
         issueT = expFire && du && dst != 0;
         wbT    = wbv && wbd != 0;
         if (wbT && pend[wbd] == 0) errM = 1'b1;
         if (!(issueT && wbT && dst == wbd)) begin
            if (wbT && pend[wbd] > 0) pend[wbd]--;
            if (issueT) pend[dst]++;
         end
      end
      @(posedge clk);
      #1;
      checkRegs("cycle");
      @(negedge clk);
   endtask

   // Assert reset asynchronously in the middle of a cycle and check that the
   // outputs clear at once
   task automatic midReset();
      reset = 1'b0;
      #1;
      clearModel();
      checkOutput("async_reset.ready", 64'(sbIf.issue_ready), 64'd0);
      checkRegs("async_reset");
      applyStimulus(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
      reset = 1'b1;
   endtask

   initial begin
      int wbd, dst;
      clearModel();
      reset = 1'b0;
      sbIf.dec_valid = 0; sbIf.dec_r1_reg = '0; sbIf.dec_r1_used = 0;
      sbIf.dec_r2_reg = '0; sbIf.dec_r2_used = 0; sbIf.dec_dst_reg = '0;
      sbIf.dec_dst_used = 0; sbIf.ex_ready = 0; sbIf.wb_valid = 0;
      sbIf.wb_dst_reg = '0; sbIf.flush = 0;
      @(negedge clk);

      // Reset held for three cycles with decode requesting
      repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("reset_ready_low", 64'(obsReady), 64'd0);
      reset = 1'b1;
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("reset_release_ready", 64'(obsReady), 64'd1);

      // RAW stall on x5, released by a same-cycle writeback bypass
      applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
      applyStimulus(1, 5, 1, 0, 0, 6, 1, 1, 0, 0, 0);
      checkOutput("raw_stall", 64'(obsReady), 64'd0);
      applyStimulus(1, 5, 1, 0, 0, 6, 1, 1, 0, 0, 0);
      checkOutput("raw_stall2", 64'(obsReady), 64'd0);
      applyStimulus(1, 5, 1, 0, 0, 6, 1, 1, 1, 5, 0);
      checkOutput("raw_bypass", 64'(obsReady), 64'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0);

      // x0 is never tracked and never a hazard
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      applyStimulus(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0);
      checkOutput("x0_no_stall", 64'(obsReady), 64'd1);
      checkOutput("x0_busy", 64'(sbIf.busy_mask), 64'd0);
      checkOutput("x0_total", 64'(sbIf.inflight_total), 64'd0);

      // Saturation of x7, then a swap of writeback and issue in one cycle
      repeat (3) applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
      checkOutput("sat_stall", 64'(obsReady), 64'd0);
      applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 1, 7, 0);
      checkOutput("sat_swap_ready", 64'(obsFire), 64'd1);
      checkOutput("sat_swap_total", 64'(sbIf.inflight_total), 64'd3);

      // Flush with four registers pending, then a wb during DRAIN is ignored
      applyStimulus(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 1);
      checkOutput("flush_fire", 64'(obsFire), 64'd0);
      checkOutput("flush_busy", 64'(sbIf.busy_mask), 64'd0);
      checkOutput("flush_total", 64'(sbIf.inflight_total), 64'd0);
      applyStimulus(1, 0, 0, 0, 0, 4, 1, 1, 1, 7, 0);
      checkOutput("drain_ready", 64'(obsReady), 64'd0);
      checkOutput("drain_wb_err", 64'(sbIf.err_underflow), 64'd0);
      applyStimulus(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0);
      checkOutput("run_after_drain", 64'(obsReady), 64'd1);

      // Underflow on x9 is sticky until reset
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0);
      checkOutput("underflow_err", 64'(sbIf.err_underflow), 64'd1);
      repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("underflow_sticky", 64'(sbIf.err_underflow), 64'd1);
      midReset();

      // Randomized traffic over a small register window so that hazards occur
      for (int n = 0; n < 600; n++) begin
         if (n % 150 == 75 || $urandom_range(0, 199) == 0) begin
            midReset();
         end else begin
            dst = $urandom_range(0, 7);
            wbd = $urandom_range(0, 7);
            // Mostly retire registers that really have pending writes
            if ($urandom_range(0, 9) != 0) begin
               for (int k = 0; k < 8; k++) begin
                  if (pend[(wbd + k) % 8] != 0) begin
                     wbd = (wbd + k) % 8;
                     break;
                  end
               end
            end
            applyStimulus($urandom_range(0, 9) < 8,
                          $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                          $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                          dst, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 4) != 0,
                          $urandom_range(0, 2) == 0, wbd,
                          $urandom_range(0, 39) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   // Hard time limit so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL timeout: observed running expected finished");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
